// File: rtl/node_injector.sv
// -----------------------------------------------------------------------------
// node_injector
//   Buffers words offered by a host in a small FIFO and replays them to a node
//   shiftIn*Data port as single-cycle strobes, with a programmable number of
//   idle cycles forced between consecutive strobes.
//
// Parameters
//   DEPTH : FIFO depth in words (power of two, >= 2)
//   GAP   : idle cycles between consecutive strobes (0..15)
//
// Ports
//   clk          : single clock, rising edge
//   reset        : synchronous, active-high
//   hostData     : word offered by the host
//   hostValid    : hostData valid this cycle
//   hostReady    : FIFO can accept a word this cycle (low while reset is high)
//   halt         : blocks launching a new strobe; FIFO keeps accepting words
//   shiftOutData : word presented to the node (registered)
//   shiftOutCS   : one-cycle strobe qualifying shiftOutData (registered)
//   count        : current FIFO occupancy
//   idle         : FSM in IDLE and FIFO empty
//
// Configuration macro
//   INJECTOR_HOLD_DATA_EN : when defined, shiftOutData holds the last sent
//                           word between strobes; otherwise it reads 0
//                           whenever shiftOutCS is low.
// -----------------------------------------------------------------------------
module node_injector #(
    parameter int DEPTH = 4,
    parameter int GAP   = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  hostData,
    input  logic                         hostValid,
    output logic                         hostReady,
    input  logic                         halt,
    output logic [31:0]                  shiftOutData,
    output logic                         shiftOutCS,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         idle
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [3:0]    GAP_C   = 4'(GAP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          r_state;
    logic [31:0]     r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [3:0]      r_gap;
    logic [31:0]     r_data;
    logic            r_cs;

    logic            w_push;
    logic            w_can_launch;
    logic            w_launch;

    // Ready is a function of occupancy only; a pop in the same cycle does not
    // make room early. Reset forces it low so nothing is accepted.
    assign hostReady    = !reset && (r_count < DEPTH_C);
    assign w_push       = hostValid && hostReady;
    assign w_can_launch = (r_count != '0) && !halt;

    // A launch pops the head this edge and raises the strobe next cycle.
    // It is only allowed at the points where the FSM re-evaluates: from IDLE,
    // from SEND when there is no gap, or on the last gap cycle of HOLD.
    always_comb begin
        w_launch = 1'b0;
        case (r_state)
            IDLE:    w_launch = w_can_launch;
            SEND:    w_launch = (GAP_C == 4'd0) && w_can_launch;
            HOLD:    w_launch = (r_gap <= 4'd1) && w_can_launch;
            default: w_launch = 1'b0;
        endcase
    end

    // Storage needs no reset: contents are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= hostData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)   r_wptr <= r_wptr + PW'(1);
            if (w_launch) r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_launch})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_gap   <= 4'd0;
            r_cs    <= 1'b0;
            r_data  <= '0;
        end else begin
            r_cs <= w_launch;
            if (w_launch) begin
                r_data <= r_mem[r_rptr];
            end else begin
`ifdef INJECTOR_HOLD_DATA_EN
                r_data <= r_data;
`else
                r_data <= '0;
`endif
            end

            case (r_state)
                IDLE: begin
                    if (w_launch) r_state <= SEND;
                end
                SEND: begin
                    if (GAP_C != 4'd0) begin
                        r_state <= HOLD;
                        r_gap   <= GAP_C;
                    end else begin
                        r_state <= w_launch ? SEND : IDLE;
                    end
                end
                HOLD: begin
                    r_gap <= r_gap - 4'd1;
                    // halt only matters here, at the end of the gap.
                    if (r_gap <= 4'd1) begin
                        r_state <= w_launch ? SEND : IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gap   <= 4'd0;
                end
            endcase
        end
    end

    assign shiftOutData = r_data;
    assign shiftOutCS   = r_cs;
    assign count        = r_count;
    assign idle         = (r_state == IDLE) && (r_count == '0);

endmodule

// File: tb/tb_node_injector.sv
module tb_node_injector;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset     = 1'b1;
    logic          hostValid = 1'b0;
    logic          halt      = 1'b0;
    logic [31:0]   hostData  = '0;

    logic          rdy0, rdy1, cs0, cs1, idle0, idle1;
    logic [31:0]   sd0, sd1;
    logic [CW-1:0] cnt0, cnt1;

    // Instance 0 uses GAP=3, instance 1 uses GAP=0; both see the same stimulus.
    node_injector #(.DEPTH(DEPTH), .GAP(3)) dut (
        .clk(clk), .reset(reset), .hostData(hostData), .hostValid(hostValid),
        .hostReady(rdy0), .halt(halt), .shiftOutData(sd0), .shiftOutCS(cs0),
        .count(cnt0), .idle(idle0));

    node_injector #(.DEPTH(DEPTH), .GAP(0)) dut0 (
        .clk(clk), .reset(reset), .hostData(hostData), .hostValid(hostValid),
        .hostReady(rdy1), .halt(halt), .shiftOutData(sd1), .shiftOutCS(cs1),
        .count(cnt1), .idle(idle1));

    // Reference model: a word queue plus the earliest edge at which the next
    // strobe may launch. A launch happens at an edge when the queue (before
    // this edge's push) is non-empty, halt is low and the spacing has elapsed.
    int          gapv [2] = '{3, 0};
    logic [31:0] mbuf [2][256];
    int          rd [2], wr [2], earliest [2];
    logic        m_cs [2], m_idle [2], m_rdy [2];
    logic [31:0] m_data [2];
    int          cyc = 0;
    int          n_assert = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit v, input logic [31:0] d, input bit h, input bit r);
        for (int k = 0; k < 2; k++) begin
            int sz;
            bit launch;
            sz = wr[k] - rd[k];
            launch = 1'b0;
            if (r) begin
                rd[k] = 0; wr[k] = 0; earliest[k] = 0;
                m_data[k] = '0;
            end else begin
                launch = (sz > 0) && !h && (cyc >= earliest[k]);
                if (launch) begin
                    m_data[k] = mbuf[k][rd[k] % 256];
                    rd[k]++;
                    earliest[k] = cyc + gapv[k] + 1;
                end else begin
`ifndef INJECTOR_HOLD_DATA_EN
                    m_data[k] = '0;
`endif
                end
                if (v && sz < DEPTH) begin
                    mbuf[k][wr[k] % 256] = d;
                    wr[k]++;
                end
            end
            m_cs[k]   = launch;
            m_idle[k] = !launch && (cyc >= earliest[k]) && (wr[k] == rd[k]);
            m_rdy[k]  = !r && ((wr[k] - rd[k]) < DEPTH);
        end
        cyc++;
    endtask

    task automatic step(input bit v, input logic [31:0] d, input bit h, input bit r);
        @(negedge clk);
        hostValid = v; hostData = d; halt = h; reset = r;
        @(posedge clk);
        model_edge(v, d, h, r);
        #1;
        chk($sformatf("cs0@%0d", cyc),    32'(cs0),   32'(m_cs[0]));
        chk($sformatf("data0@%0d", cyc),  sd0,        m_data[0]);
        chk($sformatf("count0@%0d", cyc), 32'(cnt0),  32'(wr[0] - rd[0]));
        chk($sformatf("ready0@%0d", cyc), 32'(rdy0),  32'(m_rdy[0]));
        chk($sformatf("idle0@%0d", cyc),  32'(idle0), 32'(m_idle[0]));
        chk($sformatf("cs1@%0d", cyc),    32'(cs1),   32'(m_cs[1]));
        chk($sformatf("data1@%0d", cyc),  sd1,        m_data[1]);
        chk($sformatf("count1@%0d", cyc), 32'(cnt1),  32'(wr[1] - rd[1]));
        chk($sformatf("ready1@%0d", cyc), 32'(rdy1),  32'(m_rdy[1]));
        chk($sformatf("idle1@%0d", cyc),  32'(idle1), 32'(m_idle[1]));
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rd[k] = 0; wr[k] = 0; earliest[k] = 0;
            m_cs[k] = 1'b0; m_idle[k] = 1'b1; m_rdy[k] = 1'b0; m_data[k] = '0;
        end

        // Reset state
        step(1'b1, 32'hDEAD, 1'b0, 1'b1);
        step(1'b1, 32'hBEEF, 1'b0, 1'b1);
        chk("reset_ready", 32'(rdy0), 32'd0);
        chk("reset_count", 32'(cnt0), 32'd0);

        // Single word: strobe one edge after acceptance, then idle again
        step(1'b1, 32'd42, 1'b0, 1'b0);
        chk("single_count", 32'(cnt0), 32'd1);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        chk("single_cs", 32'(cs0), 32'd1);
        chk("single_data", sd0, 32'd42);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        // First gap cycle: data held or cleared depending on build
`ifdef INJECTOR_HOLD_DATA_EN
        chk("gap_data", sd0, 32'd42);
`else
        chk("gap_data", sd0, 32'd0);
`endif
        idle_steps(4);
        chk("single_idle", 32'(idle0), 32'd1);

        // Burst of two on consecutive edges
        step(1'b1, 32'd73, 1'b0, 1'b0);
        step(1'b1, 32'd89, 1'b0, 1'b0);
        chk("burst_cs_first", 32'(cs0), 32'd1);
        chk("burst_data_first", sd0, 32'd73);
        idle_steps(3);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        chk("burst_data_second", sd0, 32'd89);
        idle_steps(5);

        // Fill under halt, fifth word ignored, then drain
        step(1'b1, 32'd1, 1'b1, 1'b0);
        step(1'b1, 32'd2, 1'b1, 1'b0);
        step(1'b1, 32'd3, 1'b1, 1'b0);
        step(1'b1, 32'd4, 1'b1, 1'b0);
        chk("full_count", 32'(cnt0), 32'd4);
        chk("full_ready", 32'(rdy0), 32'd0);
        step(1'b1, 32'd5, 1'b1, 1'b0);
        chk("full_count_after_5", 32'(cnt0), 32'd4);
        idle_steps(20);
        chk("full_drained", 32'(cnt0), 32'd0);

        // Reset one cycle after the first strobe discards the second word
        step(1'b1, 32'd1, 1'b0, 1'b0);
        step(1'b1, 32'd2, 1'b0, 1'b0);
        chk("rst_first_strobe", sd0, 32'd1);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        chk("rst_count", 32'(cnt0), 32'd0);
        chk("rst_cs", 32'(cs0), 32'd0);
        idle_steps(8);

        // GAP=0 instance: three back-to-back strobes once words are queued
        step(1'b1, 32'd500, 1'b1, 1'b0);
        step(1'b1, 32'd800, 1'b1, 1'b0);
        step(1'b1, 32'd4,   1'b1, 1'b0);
        step(1'b0, 32'd0,   1'b0, 1'b0);
        chk("gap0_a", sd1, 32'd500);
        step(1'b0, 32'd0,   1'b0, 1'b0);
        chk("gap0_b", sd1, 32'd800);
        step(1'b0, 32'd0,   1'b0, 1'b0);
        chk("gap0_c", sd1, 32'd4);
        idle_steps(12);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 3) != 0, $urandom, ($urandom % 5) == 0, ($urandom % 60) == 0);
        end
        idle_steps(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
